// File: rtl/song_note_loader_if.sv
// rtl/song_note_loader_if.sv - request/ROM/result bundle shared by song_note_loader and its requester
//
// Signals:
//   start        requester -> loader  level request, held until done is seen
//   song_sel     requester -> loader  song slot, sampled when a load begins
//   rom_addr_out loader -> ROM        registered read address
//   rom_data_in  ROM -> loader        read data, ROM_LATENCY cycles after the address
//   results      loader -> requester  note table, index 0 = first note
//   note_count   loader -> requester  number of valid notes in results
//   busy         loader -> requester  fetch in progress
//   done         loader -> requester  load complete, held while start stays high
// Modports: slave = loader side, master = requester/ROM side.

interface song_note_loader_if #(
    parameter int NUM_NOTES  = 32,
    parameter int FREQ_W     = 16,
    parameter int SONG_COUNT = 4,
    parameter int ADDR_W     = 7
);
    localparam int SEL_W = (SONG_COUNT > 1) ? $clog2(SONG_COUNT) : 1;
    localparam int NC_W  = $clog2(NUM_NOTES + 1);

    logic                                 start;
    logic [SEL_W-1:0]                     song_sel;
    logic [ADDR_W-1:0]                    rom_addr_out;
    logic [FREQ_W-1:0]                    rom_data_in;
    logic [NUM_NOTES-1:0][FREQ_W-1:0]     results;
    logic [NC_W-1:0]                      note_count;
    logic                                 busy;
    logic                                 done;

    modport slave (
        input  start, song_sel, rom_data_in,
        output rom_addr_out, results, note_count, busy, done
    );

    modport master (
        output start, song_sel, rom_data_in,
        input  rom_addr_out, results, note_count, busy, done
    );
endinterface

// File: rtl/song_note_loader.sv
// rtl/song_note_loader.sv - loads one song from a synchronous-read note ROM into a parallel note table
//
// Ports:
//   clk_in  single clock
//   rst_in  asynchronous active-low reset
//   bus     song_note_loader_if.slave: start/song_sel request, rom_addr_out/rom_data_in ROM
//           port, results/note_count/busy/done outputs (all outputs registered)

module song_note_loader #(
    parameter int                NUM_NOTES   = 32,
    parameter int                FREQ_W      = 16,
    parameter int                SONG_COUNT  = 4,
    parameter int                ADDR_W      = 7,
    parameter int                ROM_LATENCY = 2,
    parameter logic [FREQ_W-1:0] END_MARKER  = 16'hFFFF
) (
    input logic                  clk_in,
    input logic                  rst_in,
    song_note_loader_if.slave    bus
);
    localparam int NC_W  = $clog2(NUM_NOTES + 1);
    localparam int IDX_W = $clog2(NUM_NOTES) + 1;
    localparam int SIW   = $clog2(NUM_NOTES);
    // Cycle counter must reach NUM_NOTES-1+ROM_LATENCY without wrapping.
    localparam int CYC_W = $clog2(NUM_NOTES + ROM_LATENCY) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DONE
    } state_t;

    state_t                           state_q, state_d;
    logic [ADDR_W-1:0]                base_q, base_d;
    logic [ADDR_W-1:0]                addr_q, addr_d;
    logic [IDX_W-1:0]                 iss_q, iss_d;
    logic [CYC_W-1:0]                 cyc_q, cyc_d;
    logic [NUM_NOTES-1:0][FREQ_W-1:0] results_q, results_d;
    logic [NC_W-1:0]                  count_q, count_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;

    logic [CYC_W-1:0]                 cap_idx;
    logic [ADDR_W-1:0]                sel_base;

    // cyc_q is the number of edges since the start edge; the word arriving now belongs to
    // the address issued ROM_LATENCY edges ago.
    assign cap_idx  = cyc_q - CYC_W'(ROM_LATENCY);
    assign sel_base = ADDR_W'(bus.song_sel) * ADDR_W'(NUM_NOTES);

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        addr_d    = addr_q;
        iss_d     = iss_q;
        cyc_d     = cyc_q;
        results_d = results_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = done_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    base_d    = sel_base;
                    addr_d    = sel_base;
                    iss_d     = '0;
                    cyc_d     = CYC_W'(1);
                    results_d = '0;
                    busy_d    = 1'b1;
                    state_d   = S_FETCH;
                end
            end

            S_FETCH: begin
                if (!bus.start) begin
                    // Abort: anything still in flight from the ROM is dropped.
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    if (iss_q < IDX_W'(NUM_NOTES - 1)) begin
                        iss_d  = iss_q + IDX_W'(1);
                        addr_d = base_q + ADDR_W'(iss_q) + ADDR_W'(1);
                    end
                    cyc_d = cyc_q + CYC_W'(1);
                    if (cyc_q >= CYC_W'(ROM_LATENCY)) begin
                        if (bus.rom_data_in == END_MARKER) begin
                            count_d = NC_W'(cap_idx);
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            results_d[cap_idx[SIW-1:0]] = bus.rom_data_in;
                            if (cap_idx == CYC_W'(NUM_NOTES - 1)) begin
                                count_d = NC_W'(NUM_NOTES);
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                state_d = S_DONE;
                            end
                        end
                    end
                end
            end

            S_DONE: begin
                // Leaving through IDLE forces start to be seen low before another load.
                if (!bus.start) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            addr_q    <= '0;
            iss_q     <= '0;
            cyc_q     <= '0;
            results_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            iss_q     <= iss_d;
            cyc_q     <= cyc_d;
            results_q <= results_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.rom_addr_out = addr_q;
    assign bus.results      = results_q;
    assign bus.note_count   = count_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_song_note_loader.sv
// tb/tb_song_note_loader.sv - self-checking bench for song_note_loader

module tb_song_note_loader;
    localparam int NUM_NOTES   = 32;
    localparam int FREQ_W      = 16;
    localparam int SONG_COUNT  = 4;
    localparam int ADDR_W      = 7;
    localparam int ROM_LATENCY = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    song_note_loader_if #(
        .NUM_NOTES(NUM_NOTES), .FREQ_W(FREQ_W), .SONG_COUNT(SONG_COUNT), .ADDR_W(ADDR_W)
    ) bus ();

    song_note_loader #(
        .NUM_NOTES(NUM_NOTES), .FREQ_W(FREQ_W), .SONG_COUNT(SONG_COUNT), .ADDR_W(ADDR_W),
        .ROM_LATENCY(ROM_LATENCY), .END_MARKER(16'hFFFF)
    ) dut (
        .clk_in(clk),
        .rst_in(rst_n),
        .bus(bus)
    );

    // Note ROM: one register stage after the DUT's registered address gives latency 2.
    logic [FREQ_W-1:0] rom_mem [2**ADDR_W];
    logic [FREQ_W-1:0] rom_q;
    always @(posedge clk) rom_q <= rom_mem[bus.rom_addr_out];
    assign bus.rom_data_in = rom_q;

    // Scoreboard of the expected note table for the load being driven.
    logic [FREQ_W-1:0] exp_q[$];
    int exp_cnt;
    int tests = 0;
    int fails = 0;

    // Per-edge trace; index 0 is the edge that first samples start high.
    int              tr_n;
    logic [ADDR_W-1:0] tr_addr [64];
    logic            tr_busy [64];
    logic            tr_done [64];

    task automatic fill_song(input int sel, input int marker);
        logic [FREQ_W-1:0] w;
        exp_q.delete();
        for (int k = 0; k < NUM_NOTES; k++) begin
            if (k == marker) w = 16'hFFFF;
            else             w = 16'($urandom_range(1, 16'hFFFE));
            rom_mem[sel*NUM_NOTES + k] = w;
            exp_q.push_back((marker >= 0 && k >= marker) ? 16'h0000 : w);
        end
        exp_cnt = (marker < 0) ? NUM_NOTES : marker;
    endtask

    task automatic start_load(input int sel);
        bus.song_sel = 2'(sel);
        bus.start    = 1'b1;
        tr_n         = 0;
    endtask

    task automatic trace(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (tr_n < 64) begin
                tr_addr[tr_n] = bus.rom_addr_out;
                tr_busy[tr_n] = bus.busy;
                tr_done[tr_n] = bus.done;
                tr_n++;
            end
        end
    endtask

    task automatic release_start();
        bus.start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.song_sel = '0;
        #12;
        tests++; if (bus.rom_addr_out !== 7'd0) begin fails++; $display("FAIL reset_addr got %0d expected 0", bus.rom_addr_out); end
        tests++; if (bus.results !== '0) begin fails++; $display("FAIL reset_results got %h expected 0", bus.results); end
        tests++; if (bus.note_count !== 6'd0) begin fails++; $display("FAIL reset_count got %0d expected 0", bus.note_count); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b expected 0", bus.done); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_song();
        logic [FREQ_W-1:0] e;
        fill_song(0, -1);
        start_load(0);
        trace(36);
        for (int c = 0; c < 36; c++) begin
            tests++; if (tr_addr[c] !== ADDR_W'((c < 31) ? c : 31)) begin fails++; $display("FAIL full_addr E%0d got %0d expected %0d", c, tr_addr[c], (c < 31) ? c : 31); end
            tests++; if (tr_busy[c] !== (c <= 32)) begin fails++; $display("FAIL full_busy E%0d got %b expected %b", c, tr_busy[c], c <= 32); end
            tests++; if (tr_done[c] !== (c >= 33)) begin fails++; $display("FAIL full_done E%0d got %b expected %b", c, tr_done[c], c >= 33); end
        end
        tests++; if (bus.note_count !== 6'(exp_cnt)) begin fails++; $display("FAIL full_count got %0d expected %0d", bus.note_count, exp_cnt); end
        for (int k = 0; k < NUM_NOTES; k++) begin
            e = exp_q.pop_front();
            tests++; if (bus.results[k] !== e) begin fails++; $display("FAIL full_result[%0d] got %h expected %h", k, bus.results[k], e); end
        end
        release_start();
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL full_done_drop got %b expected 0", bus.done); end
    endtask

    task automatic test_marker_mid();
        logic [FREQ_W-1:0] e;
        fill_song(2, 5);
        start_load(2);
        trace(1);
        bus.song_sel = 2'd0;
        trace(11);
        for (int c = 0; c < 12; c++) begin
            if (c <= 6) begin
                tests++; if (tr_addr[c] !== ADDR_W'(64 + c)) begin fails++; $display("FAIL mid_addr E%0d got %0d expected %0d", c, tr_addr[c], 64 + c); end
            end
            tests++; if (tr_busy[c] !== (c < 7)) begin fails++; $display("FAIL mid_busy E%0d got %b expected %b", c, tr_busy[c], c < 7); end
            tests++; if (tr_done[c] !== (c >= 7)) begin fails++; $display("FAIL mid_done E%0d got %b expected %b", c, tr_done[c], c >= 7); end
        end
        tests++; if (bus.note_count !== 6'(exp_cnt)) begin fails++; $display("FAIL mid_count got %0d expected %0d", bus.note_count, exp_cnt); end
        for (int k = 0; k < NUM_NOTES; k++) begin
            e = exp_q.pop_front();
            tests++; if (bus.results[k] !== e) begin fails++; $display("FAIL mid_result[%0d] got %h expected %h", k, bus.results[k], e); end
        end
        release_start();
    endtask

    task automatic test_marker_first();
        logic [FREQ_W-1:0] e;
        fill_song(1, 0);
        start_load(1);
        trace(6);
        tests++; if (tr_addr[0] !== 7'd32) begin fails++; $display("FAIL first_addr got %0d expected 32", tr_addr[0]); end
        for (int c = 0; c < 6; c++) begin
            tests++; if (tr_done[c] !== (c >= 2)) begin fails++; $display("FAIL first_done E%0d got %b expected %b", c, tr_done[c], c >= 2); end
        end
        tests++; if (bus.note_count !== 6'(exp_cnt)) begin fails++; $display("FAIL first_count got %0d expected %0d", bus.note_count, exp_cnt); end
        for (int k = 0; k < NUM_NOTES; k++) begin
            e = exp_q.pop_front();
            tests++; if (bus.results[k] !== e) begin fails++; $display("FAIL first_result[%0d] got %h expected %h", k, bus.results[k], e); end
        end
        release_start();
    endtask

    task automatic test_hold_and_restart();
        logic [FREQ_W-1:0] e;
        fill_song(0, -1);
        start_load(0);
        trace(44);
        for (int c = 33; c < 44; c++) begin
            tests++; if (tr_done[c] !== 1'b1) begin fails++; $display("FAIL hold_done E%0d got %b expected 1", c, tr_done[c]); end
            tests++; if (tr_busy[c] !== 1'b0) begin fails++; $display("FAIL hold_busy E%0d got %b expected 0", c, tr_busy[c]); end
        end
        tests++; if (bus.note_count !== 6'(exp_cnt)) begin fails++; $display("FAIL hold_count got %0d expected %0d", bus.note_count, exp_cnt); end
        for (int k = 0; k < NUM_NOTES; k++) begin
            e = exp_q.pop_front();
            tests++; if (bus.results[k] !== e) begin fails++; $display("FAIL hold_result[%0d] got %h expected %h", k, bus.results[k], e); end
        end
        release_start();
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL hold_done_drop got %b expected 0", bus.done); end

        fill_song(3, -1);
        start_load(3);
        trace(34);
        tests++; if (tr_addr[0] !== 7'd96) begin fails++; $display("FAIL restart_first_addr got %0d expected 96", tr_addr[0]); end
        tests++; if (tr_addr[31] !== 7'd127) begin fails++; $display("FAIL restart_last_addr got %0d expected 127", tr_addr[31]); end
        tests++; if (tr_done[32] !== 1'b0 || tr_done[33] !== 1'b1) begin fails++; $display("FAIL restart_done_edge got E32=%b E33=%b expected 0 1", tr_done[32], tr_done[33]); end
        for (int k = 0; k < NUM_NOTES; k++) begin
            e = exp_q.pop_front();
            tests++; if (bus.results[k] !== e) begin fails++; $display("FAIL restart_result[%0d] got %h expected %h", k, bus.results[k], e); end
        end
        release_start();
    endtask

    task automatic test_abort();
        int prev_cnt;
        prev_cnt = exp_cnt;
        fill_song(1, -1);
        start_load(1);
        trace(10);
        bus.start = 1'b0;
        trace(6);
        for (int c = 0; c < 16; c++) begin
            tests++; if (tr_busy[c] !== (c < 10)) begin fails++; $display("FAIL abort_busy E%0d got %b expected %b", c, tr_busy[c], c < 10); end
            tests++; if (tr_done[c] !== 1'b0) begin fails++; $display("FAIL abort_done E%0d got %b expected 0", c, tr_done[c]); end
        end
        tests++; if (bus.note_count !== 6'(prev_cnt)) begin fails++; $display("FAIL abort_count got %0d expected %0d", bus.note_count, prev_cnt); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_load();
        logic [FREQ_W-1:0] e;
        fill_song(2, -1);
        start_load(2);
        trace(5);
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.rom_addr_out !== 7'd0) begin fails++; $display("FAIL midrst_addr got %0d expected 0", bus.rom_addr_out); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b expected 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL midrst_done got %b expected 0", bus.done); end
        tests++; if (bus.note_count !== 6'd0) begin fails++; $display("FAIL midrst_count got %0d expected 0", bus.note_count); end
        tests++; if (bus.results !== '0) begin fails++; $display("FAIL midrst_results got %h expected 0", bus.results); end
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        fill_song(2, 9);
        start_load(2);
        trace(14);
        tests++; if (tr_addr[0] !== 7'd64) begin fails++; $display("FAIL reload_addr got %0d expected 64", tr_addr[0]); end
        for (int c = 0; c < 14; c++) begin
            tests++; if (tr_done[c] !== (c >= 11)) begin fails++; $display("FAIL reload_done E%0d got %b expected %b", c, tr_done[c], c >= 11); end
        end
        tests++; if (bus.note_count !== 6'(exp_cnt)) begin fails++; $display("FAIL reload_count got %0d expected %0d", bus.note_count, exp_cnt); end
        for (int k = 0; k < NUM_NOTES; k++) begin
            e = exp_q.pop_front();
            tests++; if (bus.results[k] !== e) begin fails++; $display("FAIL reload_result[%0d] got %h expected %h", k, bus.results[k], e); end
        end
        release_start();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 2**ADDR_W; a++) rom_mem[a] = '0;
        rom_q = '0;
        test_reset();
        test_full_song();
        test_marker_mid();
        test_marker_first();
        test_hold_and_restart();
        test_abort();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
